// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states; the unused code 2'd3 falls back to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_fs_cell.sv
// Combinational full subtractor: d = a - b - bin, built from two
// half-subtractor stages whose borrows are ORed together.
module fs_cell (
    input  logic a_in,
    input  logic b_in,
    input  logic bin_in,
    output logic diff_out,
    output logic borrow_out
);

    logic d1, b1, b2;

    // Stage 1: a - b
    assign d1 = a_in ^ b_in;
    assign b1 = ~a_in & b_in;

    // Stage 2: (a - b) - bin
    assign diff_out   = d1 ^ bin_in;
    assign b2         = ~d1 & bin_in;
    assign borrow_out = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per cycle LSB
// first, through a single full-subtractor cell and a registered borrow.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   a_sr_q, b_sr_q, res_sr_q;
    logic [WIDTH-1:0]   diff_q;
    logic               brw_q, borrow_q, done_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               d_bit, bo_bit;
    logic               last_bit;
    logic [WIDTH-1:0]   res_next;

    fs_cell u_fs (
        .a_in      (a_sr_q[0]),
        .b_in      (b_sr_q[0]),
        .bin_in    (brw_q),
        .diff_out  (d_bit),
        .borrow_out(bo_bit)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // Result register with the bit produced this cycle shifted in at the MSB.
    assign res_next = {d_bit, res_sr_q[WIDTH-1:1]};

    assign ready_out  = (state_q == S_IDLE);
    assign busy_out   = (state_q == S_SHIFT);
    assign done_out   = done_q;
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;

    // Controller, datapath shift registers and result holding registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_in) begin
                        a_sr_q  <= a_in;
                        b_sr_q  <= b_in;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_next;
                    brw_q    <= bo_bit;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // Publish including the bit computed on this edge.
                        diff_q   <= res_next;
                        borrow_q <= bo_bit;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8 and WIDTH=2.
module tb_serial_sub;

    typedef struct {
        logic [7:0] d;
        logic       b;
        int         due;
        bit         b2b;
    } exp8_t;

    typedef struct {
        logic [1:0] d;
        logic       b;
        int         due;
    } exp2_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;

    logic       start8 = 1'b0, start2 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       rdy8, busy8, done8, brw8;
    logic       rdy2, busy2, done2, brw2;
    logic [7:0] diff8;
    logic [1:0] diff2;

    exp8_t      q8[$];
    exp2_t      q2[$];
    int         tests = 0;
    int         fails = 0;

    // Expected held result (from the model, never from the DUT)
    logic [7:0] hold_d8 = '0;
    logic       hold_b8 = 1'b0;
    logic [1:0] hold_d2 = '0;
    logic       hold_b2 = 1'b0;
    int         last_done8 = -100;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst), .start_in(start8), .a_in(a8), .b_in(b8),
        .ready_out(rdy8), .busy_out(busy8), .done_out(done8),
        .diff_out(diff8), .borrow_out(brw8)
    );

    serial_sub #(.WIDTH(2)) dut2 (
        .clk_in(clk), .rst_in(rst), .start_in(start2), .a_in(a2), .b_in(b2),
        .ready_out(rdy2), .busy_out(busy2), .done_out(done2),
        .diff_out(diff2), .borrow_out(brw2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks held outputs while busy.
    always @(negedge clk) begin
        exp8_t e8;
        exp2_t e2;
        if (rst) begin
            hold_d8 = '0; hold_b8 = 1'b0;
            hold_d2 = '0; hold_b2 = 1'b0;
        end else begin
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 32'(done8), 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    chk("diff8", 32'(diff8), 32'(e8.d));
                    chk("borrow8", 32'(brw8), 32'(e8.b));
                    chk("latency8", 32'(cyc), 32'(e8.due));
                    if (e8.b2b) chk("spacing8", 32'(cyc - last_done8), 32'd10);
                    hold_d8 = e8.d; hold_b8 = e8.b;
                    last_done8 = cyc;
                end
            end else if (busy8) begin
                chk("hold_diff8", 32'(diff8), 32'(hold_d8));
                chk("hold_borrow8", 32'(brw8), 32'(hold_b8));
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_done2", 32'(done2), 32'd0);
                end else begin
                    e2 = q2.pop_front();
                    chk("diff2", 32'(diff2), 32'(e2.d));
                    chk("borrow2", 32'(brw2), 32'(e2.b));
                    chk("latency2", 32'(cyc), 32'(e2.due));
                    hold_d2 = e2.d; hold_b2 = e2.b;
                end
            end else if (busy2) begin
                chk("hold_diff2", 32'(diff2), 32'(hold_d2));
            end
        end
    end

    // Issue one op on the 8-bit DUT; called at a negedge, returns at a negedge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold, input bit b2b);
        exp8_t e;
        int n = 0;
        while (!rdy8 && n < 100) begin @(negedge clk); n++; end
        if (!rdy8) begin chk("ready8_timeout", 32'(rdy8), 32'd1); return; end
        a8 = a; b8 = b; start8 = 1'b1;
        e.d = a - b; e.b = (a < b); e.due = cyc + 1 + 8; e.b2b = b2b;
        q8.push_back(e);
        @(negedge clk);
        if (!hold) start8 = 1'b0;
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input bit hold);
        exp2_t e;
        int n = 0;
        while (!rdy2 && n < 100) begin @(negedge clk); n++; end
        if (!rdy2) begin chk("ready2_timeout", 32'(rdy2), 32'd1); return; end
        a2 = a; b2 = b; start2 = 1'b1;
        e.d = a - b; e.b = (a < b); e.due = cyc + 1 + 2;
        q2.push_back(e);
        @(negedge clk);
        if (!hold) start2 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q2.size() != 0 || !rdy8 || !rdy2) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("drain_pending", 32'(q8.size() + q2.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 32'(rdy8), 32'd1);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_borrow", 32'(brw8), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        op8(8'd200, 8'd55, 0, 0);   // 145, no borrow
        drain();
        op8(8'd5, 8'd10, 0, 0);     // FB, borrow
        op8(8'hAA, 8'hAA, 0, 0);    // 0, no borrow
        op8(8'h00, 8'hFF, 0, 0);    // 01, borrow
        drain();

        // Reset in the middle of an op: aborts, clears the held result
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_diff", 32'(diff8), 32'd0);
        chk("midrst_borrow", 32'(brw8), 32'd0);
        chk("midrst_ready", 32'(rdy8), 32'd1);
        chk("midrst_busy", 32'(busy8), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (12) @(negedge clk);   // monitor flags any stray done
        chk("postrst_ready", 32'(rdy8), 32'd1);
        chk("postrst_diff", 32'(diff8), 32'd0);

        // start during SHIFT with new operands is ignored
        op8(8'd100, 8'd1, 0, 0);    // 99
        repeat (2) @(negedge clk);
        a8 = 8'd3; b8 = 8'd9; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // Back-to-back with start held high
        op8(8'h12, 8'h34, 1, 0);    // DE, borrow
        op8(8'hFF, 8'h01, 1, 1);    // FE
        op8(8'h80, 8'h7F, 1, 1);    // 01
        op8(8'h7F, 8'h80, 0, 1);    // FF, borrow
        drain();

        // WIDTH=2 directed corners
        op2(2'd3, 2'd1, 0);
        op2(2'd0, 2'd3, 0);
        op2(2'd2, 2'd2, 0);
        drain();

        // Random ops on both widths in parallel
        fork
            begin
                for (int i = 0; i < 1000; i++)
                    op8(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), 0);
                start8 = 1'b0;
            end
            begin
                for (int j = 0; j < 1000; j++)
                    op2(2'($urandom), 2'($urandom), bit'($urandom_range(0, 1)));
                start2 = 1'b0;
            end
        join
        drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
